// File: rtl/window_gen_kxk.sv
// K x K sliding-window generator for raster pixel streams. K-1 cascaded line
// buffers feed a K x K tap array; windows are border-masked (PAD_MODE=1) or gated.
module window_gen_kxk #(
  parameter int DW       = 8,
  parameter int K        = 5,
  parameter int W        = 3124,
  parameter int PAD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DW-1:0]     in_pixel,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic [K*K*DW-1:0] out_win
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = $clog2(K);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [CW-1:0] COL_FULL = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(K - 1);

  logic [CW-1:0]     col, pc;
  logic [RW-1:0]     row, pr;
  logic [DW-1:0]     lb       [K-1][W];
  logic [DW-1:0]     lb_rd    [K-1];
  logic [DW-1:0]     taps     [K][K];
  logic [DW-1:0]     taps_nxt [K][K];
  logic [K*K*DW-1:0] win_nxt;

  // A frame start forces the accepted pixel to position (0,0) regardless of the counters.
  always_comb begin
    pc = in_sof ? '0 : col;
    pr = in_sof ? '0 : row;
  end

  // Asynchronous read so the line buffer returns the old word before this cycle's write.
  always_comb begin
    for (int j = 0; j < K - 1; j++) lb_rd[j] = lb[j][pc];
  end

  always_comb begin
    taps_nxt = taps;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K - 1; c++) taps_nxt[r][c] = taps[r][c+1];
    for (int r = 0; r < K - 1; r++) taps_nxt[r][K-1] = lb_rd[K-2-r];
    taps_nxt[K-1][K-1] = in_pixel;
  end

  // Taps above the first row or left of the first column hold stale or wrapped data.
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        if (!(PAD_MODE != 0 && (int'(pr) < K - 1 - r || int'(pc) < K - 1 - c)))
          win_nxt[(r*K+c)*DW +: DW] = taps_nxt[r][c];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      taps      <= '{default: '0};
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_win   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        taps      <= taps_nxt;
        out_win   <= win_nxt;
        out_valid <= (PAD_MODE != 0) || (pc >= COL_FULL && pr >= ROW_FULL);
        out_sof   <= in_sof;
        out_eol   <= (pc == COL_LAST);
        if (pc == COL_LAST) begin
          col <= '0;
          row <= (pr == ROW_FULL) ? pr : pr + 1'b1;
        end else begin
          col <= pc + 1'b1;
          row <= pr;
        end
      end
    end
  end

  // NOTE: line buffer storage has no reset; stale words are never exposed unmasked.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb[0][pc] <= in_pixel;
      for (int j = 1; j < K - 1; j++) lb[j][pc] <= lb_rd[j-1];
    end
  end

endmodule

// File: tb/tb_window_gen_kxk.sv
// Directed bench for window_gen_kxk: K=3/W=8 in both pad modes and K=7/DW=12/W=16
// checked against a K x K reference built from the bench's own copy of the frame.
module tb_window_gen_kxk;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [11:0] in_pixel = '0;

  logic         v3a, s3a, e3a, v3b, s3b, e3b;
  logic         v7a, s7a, e7a, v7b, s7b, e7b;
  logic [71:0]  w3a, w3b;
  logic [587:0] w7a, w7b;

  int n_checks = 0;
  int n_errors = 0;
  int nvalid   = 0;
  int first    = -1;
  logic [11:0] img [16][16];

  always #5 clk = ~clk;

  window_gen_kxk #(.DW(8), .K(3), .W(8), .PAD_MODE(0)) u3a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel[7:0]),
    .out_valid(v3a), .out_sof(s3a), .out_eol(e3a), .out_win(w3a));
  window_gen_kxk #(.DW(8), .K(3), .W(8), .PAD_MODE(1)) u3b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel[7:0]),
    .out_valid(v3b), .out_sof(s3b), .out_eol(e3b), .out_win(w3b));
  window_gen_kxk #(.DW(12), .K(7), .W(16), .PAD_MODE(0)) u7a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(v7a), .out_sof(s7a), .out_eol(e7a), .out_win(w7a));
  window_gen_kxk #(.DW(12), .K(7), .W(16), .PAD_MODE(1)) u7b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(v7b), .out_sof(s7b), .out_eol(e7b), .out_win(w7b));

  task automatic check(input string tag, input logic [587:0] obs, input logic [587:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference window: tap (r,c) is pixel (pr-(k-1)+r, pc-(k-1)+c), zero outside the frame.
  function automatic logic [587:0] ref_win(input int k, input int dw, input int pr, input int pc);
    logic [587:0] w = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++) begin
        int ir = pr - (k - 1) + r;
        int ic = pc - (k - 1) + c;
        if (ir >= 0 && ic >= 0)
          for (int b = 0; b < dw; b++) w[(r*k+c)*dw + b] = img[ir][ic][b];
      end
    return w;
  endfunction

  function automatic logic [587:0] pack3(input int v [9]);
    logic [587:0] w = '0;
    for (int t = 0; t < 9; t++)
      for (int b = 0; b < 8; b++) w[t*8 + b] = v[t][b];
    return w;
  endfunction

  task automatic drive(input logic sof, input logic [11:0] pix);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic step3(input int pr, input int pc, input logic sof, input logic [7:0] pix);
    logic vexp = (pr >= 2 && pc >= 2);
    img[pr][pc] = {4'h0, pix};
    drive(sof, {4'h0, pix});
    check($sformatf("v3a@%0d,%0d", pr, pc), v3a, vexp);
    check($sformatf("v3b@%0d,%0d", pr, pc), v3b, 1'b1);
    if (vexp) check($sformatf("w3a@%0d,%0d", pr, pc), w3a, ref_win(3, 8, pr, pc));
    check($sformatf("w3b@%0d,%0d", pr, pc), w3b, ref_win(3, 8, pr, pc));
    check($sformatf("sof3@%0d,%0d", pr, pc), {s3a, s3b}, {sof, sof});
    check($sformatf("eol3@%0d,%0d", pr, pc), {e3a, e3b}, {2{pc == 7}});
    if (v3a) nvalid++;
    if (v3a && first < 0) first = pr * 8 + pc;
  endtask

  task automatic step7(input int pr, input int pc, input logic sof, input logic [11:0] pix);
    logic vexp = (pr >= 6 && pc >= 6);
    img[pr][pc] = pix;
    drive(sof, pix);
    check($sformatf("v7a@%0d,%0d", pr, pc), v7a, vexp);
    check($sformatf("v7b@%0d,%0d", pr, pc), v7b, 1'b1);
    if (vexp) check($sformatf("w7a@%0d,%0d", pr, pc), w7a, ref_win(7, 12, pr, pc));
    check($sformatf("w7b@%0d,%0d", pr, pc), w7b, ref_win(7, 12, pr, pc));
    check($sformatf("sof7@%0d,%0d", pr, pc), {s7a, s7b}, {sof, sof});
    check($sformatf("eol7@%0d,%0d", pr, pc), {e7a, e7b}, {2{pc == 15}});
    if (v7a) nvalid++;
  endtask

  // Idle cycles: out_valid drops, the window bus holds the last value.
  task automatic gap(input int n, input int pr, input int pc);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("gap_valid", {v3a, v3b}, 2'b00);
      check("gap_hold", w3b, ref_win(3, 8, pr, pc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_valid", {v3a, v3b, v7a, v7b}, 4'b0000);
    check("rst_flags", {s3a, e3a, s3b, e3b}, 4'b0000);
    check("rst_win3", {w3a, w3b}, '0);
    check("rst_win7", w7b, '0);
    @(negedge clk) rst = 1'b0;

    // Partial stream, then reset mid-stream: outputs clear without a clock edge.
    for (int i = 0; i < 10; i++) step3(i / 8, i % 8, i == 0, 8'(50 + i));
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_valid", {v3a, v3b}, 2'b00);
    check("midrst_win", w3b, '0);
    check("midrst_flags", {s3b, e3b, e3a}, 3'b000);
    @(negedge clk) rst = 1'b0;

    // Ramp without sof: counters start at (0,0) after reset.
    nvalid = 0;
    first  = -1;
    for (int i = 0; i < 32; i++) begin
      step3(i / 8, i % 8, 1'b0, 8'(8 * (i / 8) + i % 8));
      if (i == 0)  check("pad_0_0", w3b, pack3('{0, 0, 0, 0, 0, 0, 0, 0, 0}));
      if (i == 8)  check("pad_1_0", w3b, pack3('{0, 0, 0, 0, 0, 0, 0, 0, 8}));
      if (i == 18) check("ramp_2_2", w3a, pack3('{0, 1, 2, 8, 9, 10, 16, 17, 18}));
      if (i == 31) begin
        check("pad_3_7", w3b, pack3('{13, 14, 15, 21, 22, 23, 29, 30, 31}));
        check("eol_3_7", e3b, 1'b1);
      end
    end
    check("first_valid", first, 18);
    check("ramp_nvalid", nvalid, 12);

    // Same frame with idle gaps, restarted by sof.
    nvalid = 0;
    for (int i = 0; i < 32; i++) begin
      step3(i / 8, i % 8, i == 0, 8'(8 * (i / 8) + i % 8));
      if (i % 3 == 1) gap(i % 4 + 1, i / 8, i % 8);
    end
    check("stall_nvalid", nvalid, 12);

    // 2.5 lines of one frame, then a new frame starts with pixel 100.
    for (int i = 0; i < 20; i++) step3(i / 8, i % 8, i == 0, 8'(200 + i));
    step3(0, 0, 1'b1, 8'd100);
    check("sof_win", w3b, pack3('{0, 0, 0, 0, 0, 0, 0, 0, 100}));
    check("sof_flag", s3b, 1'b1);
    nvalid = 0;
    for (int i = 1; i < 32; i++) step3(i / 8, i % 8, 1'b0, 8'(100 + i));
    check("sof_nvalid", nvalid, 12);

    // K=7, DW=12, W=16 random frame against the reference.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 144; i++) step7(i / 16, i % 16, i == 0, 12'($urandom_range(0, 4095)));
    check("k7_nvalid", nvalid, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
